// File: rtl/id_operand_stage_pkg.sv
// id_operand_stage_pkg: shared widths for the decode operand stage and its bypass bus.
`ifndef ID_OPERAND_STAGE_PKG_SV
`define ID_OPERAND_STAGE_PKG_SV
`define ID_FWD_SLICE_W(xlen, aw) (1 + (aw) + (xlen))
`define ID_FWD_BUS_W(xlen, aw, nf) ((nf) * `ID_FWD_SLICE_W(xlen, aw))
`endif

package id_operand_stage_pkg;
    localparam int DEF_XLEN = 32;
    localparam int DEF_AW = 5;
    localparam int DEF_NUM_SRC = 2;
    localparam int DEF_NUM_FWD = 3;
    localparam int DEF_PAYLOAD_W = 64;

    function automatic int fwd_slice_w(input int xlen, input int aw);
        return 1 + aw + xlen;
    endfunction
endpackage

// File: rtl/id_operand_stage_operand_bypass_mux.sv
// operand_bypass_mux: resolves one source operand over the priority bypass network.
module operand_bypass_mux
    import id_operand_stage_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int AW = DEF_AW,
    parameter int NUM_FWD = DEF_NUM_FWD
) (
    input  logic                    stage_valid,
    input  logic [AW-1:0]           src_addr,
    input  logic                    src_use,
    input  logic [XLEN-1:0]         rf_data,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [NUM_FWD*AW-1:0]   fwd_waddr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]      fwd_data_ok,
    output logic [XLEN-1:0]         data,
    output logic                    hazard
);
    logic hit;
    logic hit_ok;

    // Scan oldest to youngest so the youngest matching producer is the last one to win.
    always_comb begin
        data = rf_data;
        hit = 1'b0;
        hit_ok = 1'b1;
        for (int f = NUM_FWD - 1; f >= 0; f--) begin
            if (fwd_valid[f] && fwd_we[f] && fwd_waddr[f*AW +: AW] == src_addr && src_addr != '0) begin
                data = fwd_wdata[f*XLEN +: XLEN];
                hit = 1'b1;
                hit_ok = fwd_data_ok[f];
            end
        end
    end

    assign hazard = stage_valid & src_use & hit & ~hit_ok;
endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: IF->ID register, regfile read, bypass and load-use interlock.
// Optional macro ID_STALL_CNT_EN adds a 32-bit interlock cycle counter on stall_cnt.
module id_operand_stage
    import id_operand_stage_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int AW = DEF_AW,
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int NUM_FWD = DEF_NUM_FWD,
    parameter int PAYLOAD_W = DEF_PAYLOAD_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_allow_in,
    input  logic [PAYLOAD_W-1:0]    in_payload,
    input  logic [NUM_SRC*AW-1:0]   in_src_addr,
    input  logic [NUM_SRC-1:0]      in_src_use,
    input  logic                    flush,
    output logic [NUM_SRC*AW-1:0]   rf_raddr,
    input  logic [NUM_SRC*XLEN-1:0] rf_rdata,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [NUM_FWD*AW-1:0]   fwd_waddr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]      fwd_data_ok,
    input  logic                    out_allow_in,
    output logic                    out_valid,
    output logic [PAYLOAD_W-1:0]    out_payload,
    output logic [NUM_SRC*XLEN-1:0] out_src_data,
    output logic [31:0]             stall_cnt
);
    logic                  stage_valid;
    logic [PAYLOAD_W-1:0]  payload_q;
    logic [NUM_SRC*AW-1:0] src_addr_q;
    logic [NUM_SRC-1:0]    src_use_q;
    logic [NUM_SRC-1:0]    hazard;
    logic                  ready_go;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        operand_bypass_mux #(.XLEN(XLEN), .AW(AW), .NUM_FWD(NUM_FWD)) u_mux (
            .stage_valid(stage_valid),
            .src_addr(src_addr_q[k*AW +: AW]),
            .src_use(src_use_q[k]),
            .rf_data(rf_rdata[k*XLEN +: XLEN]),
            .fwd_valid(fwd_valid),
            .fwd_we(fwd_we),
            .fwd_waddr(fwd_waddr),
            .fwd_wdata(fwd_wdata),
            .fwd_data_ok(fwd_data_ok),
            .data(out_src_data[k*XLEN +: XLEN]),
            .hazard(hazard[k])
        );
    end

    assign ready_go = ~|hazard;
    assign out_valid = stage_valid & ready_go;
    assign in_allow_in = ~stage_valid | (ready_go & out_allow_in);
    assign rf_raddr = src_addr_q;
    assign out_payload = payload_q;

    // Occupancy: flush empties the stage even if EXE takes the instruction this cycle.
    always_ff @(posedge clk) begin
        if (reset) stage_valid <= 1'b0;
        else if (flush) stage_valid <= 1'b0;
        else if (in_allow_in) stage_valid <= in_valid;
    end

    // Capture the incoming instruction; a flush leaves the held copy untouched.
    always_ff @(posedge clk) begin
        if (in_allow_in && in_valid && !flush) begin
            payload_q <= in_payload;
            src_addr_q <= in_src_addr;
            src_use_q <= in_src_use;
        end
    end

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_q;

    // Count interlocked cycles that are not being cancelled; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) stall_q <= '0;
        else if (stage_valid && !ready_go && !flush) stall_q <= stall_q + 32'd1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif
endmodule
